// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, status bit positions.
package alu_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned STAT_W = 5;

  localparam logic [OP_W-1:0] OP_TRAP  = 5'd0;
  localparam logic [OP_W-1:0] OP_NOP   = 5'd1;
  localparam logic [OP_W-1:0] OP_NOT   = 5'd2;
  localparam logic [OP_W-1:0] OP_AND   = 5'd3;
  localparam logic [OP_W-1:0] OP_OR    = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd5;
  localparam logic [OP_W-1:0] OP_SHL   = 5'd6;
  localparam logic [OP_W-1:0] OP_SHR   = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL   = 5'd8;
  localparam logic [OP_W-1:0] OP_ROR   = 5'd9;
  localparam logic [OP_W-1:0] OP_INC   = 5'd10;
  localparam logic [OP_W-1:0] OP_DEC   = 5'd11;
  localparam logic [OP_W-1:0] OP_ADD   = 5'd12;
  localparam logic [OP_W-1:0] OP_ADC   = 5'd13;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd14;
  localparam logic [OP_W-1:0] OP_SBC   = 5'd15;
  localparam logic [OP_W-1:0] OP_EQ    = 5'd16;
  localparam logic [OP_W-1:0] OP_GT    = 5'd17;
  localparam logic [OP_W-1:0] OP_LT    = 5'd18;
  localparam logic [OP_W-1:0] OP_GE    = 5'd19;
  localparam logic [OP_W-1:0] OP_LE    = 5'd20;
  localparam logic [OP_W-1:0] OP_LSTAT = 5'd21;
  localparam logic [OP_W-1:0] OP_XSTAT = 5'd22;
  localparam logic [OP_W-1:0] OP_RTT   = 5'd23;

  // status = {trap, overflow, sign, carry, zero}
  localparam int unsigned STAT_ZERO  = 0;
  localparam int unsigned STAT_CARRY = 1;
  localparam int unsigned STAT_SIGN  = 2;
  localparam int unsigned STAT_OVF   = 3;
  localparam int unsigned STAT_TRAP  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/seq_alu_comb.sv
// Single-cycle ALU datapath: result and next status for every non-iterative op.
// Shift/rotate opcodes return the masked operand, which is the n = 0 outcome.
module seq_alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 20
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic              mode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [STAT_W-1:0] status,
  output logic [WIDTH-1:0]  res_c,
  output logic [STAT_W-1:0] status_c
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned W1   = WIDTH + 1;

  logic [WIDTH-1:0] mask, am, bm, opb;
  logic [WIDTH:0]   sum;
  logic             cin, is_sub, cout, sa, sb, sr, wr_zs;

  // Shared adder/subtractor; carry and sign are taken at bit W_eff-1/W_eff
  always_comb begin
    mask   = mode ? '1 : WIDTH'({HALF{1'b1}});
    am     = a & mask;
    bm     = b & mask;
    opb    = bm;
    cin    = 1'b0;
    is_sub = 1'b0;
    case (opcode)
      OP_INC: opb = WIDTH'(1);
      OP_DEC: begin
        opb    = WIDTH'(1);
        is_sub = 1'b1;
      end
      OP_ADC: cin = status[STAT_CARRY];
      OP_SUB: is_sub = 1'b1;
      OP_SBC: begin
        cin    = status[STAT_CARRY];
        is_sub = 1'b1;
      end
      default: ;
    endcase
    sum  = is_sub ? ({1'b0, am} - {1'b0, opb} - W1'(cin))
                  : ({1'b0, am} + {1'b0, opb} + W1'(cin));
    cout = mode ? sum[WIDTH] : sum[HALF];
    sa   = mode ? am[WIDTH-1]  : am[HALF-1];
    sb   = mode ? opb[WIDTH-1] : opb[HALF-1];
    sr   = mode ? sum[WIDTH-1] : sum[HALF-1];
  end

  always_comb begin
    res_c    = '0;
    status_c = status;
    wr_zs    = 1'b0;
    case (opcode)
      OP_NOT: begin res_c = ~am & mask; wr_zs = 1'b1; end
      OP_AND: begin res_c = am & bm;    wr_zs = 1'b1; end
      OP_OR:  begin res_c = am | bm;    wr_zs = 1'b1; end
      OP_XOR: begin res_c = am ^ bm;    wr_zs = 1'b1; end
      OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
        res_c = am;
        wr_zs = 1'b1;
      end
      OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res_c                = sum[WIDTH-1:0] & mask;
        wr_zs                = 1'b1;
        status_c[STAT_CARRY] = cout;
        status_c[STAT_OVF]   = is_sub ? ((sa != sb) && (sr != sa))
                                      : ((sa == sb) && (sr != sa));
      end
      OP_EQ: status_c[STAT_ZERO] = (am == bm);
      OP_GT: status_c[STAT_SIGN] = (am <= bm);
      OP_LT: status_c[STAT_SIGN] = (am < bm);
      OP_GE: begin
        status_c[STAT_ZERO] = (am >= bm);
        status_c[STAT_SIGN] = (am < bm);
      end
      OP_LE: begin
        status_c[STAT_ZERO] = (am <= bm);
        status_c[STAT_SIGN] = (am <= bm);
      end
      OP_TRAP:  status_c[STAT_TRAP] = 1'b1;
      OP_RTT:   status_c[STAT_TRAP] = 1'b0;
      OP_LSTAT: res_c = WIDTH'(status) & mask;
      OP_XSTAT: res_c = status[STAT_TRAP] ? ((am ^ WIDTH'(status)) & mask) : '0;
      OP_NOP:   ;
      default:  ;
    endcase
    if (wr_zs) begin
      status_c[STAT_ZERO] = (res_c == '0);
      status_c[STAT_SIGN] = mode ? res_c[WIDTH-1] : res_c[HALF-1];
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes, registered status and
// bit-serial shifts/rotates; single-cycle ops come from seq_alu_comb.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       status
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  result_q, result_d, sh_q, sh_d;
  logic [STAT_W-1:0] status_q, status_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              mode_q, mode_d, cy_q, cy_d, out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  res_c, in_mask, sh_mask, step_v;
  logic [STAT_W-1:0] status_c;
  logic [AMT_W-1:0]  amt, weff, n_amt;
  logic              step_cy, accept, is_shift;

  seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .opcode   (opcode),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .status   (status_q),
    .res_c    (res_c),
    .status_c (status_c)
  );

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status    = status_q;

  assign in_mask  = mode ? '1 : WIDTH'({HALF{1'b1}});
  assign amt      = b[AMT_W-1:0];
  assign weff     = mode ? AMT_W'(WIDTH) : AMT_W'(HALF);
  assign n_amt    = (amt > weff) ? weff : amt;
  assign is_shift = (opcode == OP_SHL) || (opcode == OP_SHR) ||
                    (opcode == OP_ROL) || (opcode == OP_ROR);

  // One bit of shift/rotate per cycle on the latched operand
  always_comb begin
    sh_mask = mode_q ? '1 : WIDTH'({HALF{1'b1}});
    step_v  = sh_q;
    step_cy = cy_q;
    case (op_q)
      OP_SHL: begin
        step_v  = (sh_q << 1) & sh_mask;
        step_cy = mode_q ? sh_q[WIDTH-1] : sh_q[HALF-1];
      end
      OP_SHR: begin
        step_v  = sh_q >> 1;
        step_cy = sh_q[0];
      end
      OP_ROL: step_v = ((sh_q << 1) | WIDTH'(mode_q ? sh_q[WIDTH-1] : sh_q[HALF-1])) & sh_mask;
      OP_ROR: step_v = (sh_q >> 1) | (mode_q ? {sh_q[0], {(WIDTH-1){1'b0}}}
                                             : WIDTH'({sh_q[0], {(HALF-1){1'b0}}}));
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    mode_d      = mode_q;
    cy_d        = cy_q;

    case (state_q)
      S_SHIFT: begin
        sh_d  = step_v;
        cy_d  = step_cy;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d              = S_DONE;
          out_valid_d          = 1'b1;
          result_d             = step_v;
          status_d[STAT_CARRY] = step_cy;
          status_d[STAT_ZERO]  = (step_v == '0);
          status_d[STAT_SIGN]  = mode_q ? step_v[WIDTH-1] : step_v[HALF-1];
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Acceptance overrides the DONE->IDLE exit for back-to-back ops
    if (accept) begin
      if (is_shift && (n_amt != '0)) begin
        state_d     = S_SHIFT;
        out_valid_d = 1'b0;
        sh_d        = a & in_mask;
        cnt_d       = n_amt;
        op_d        = opcode;
        mode_d      = mode;
        cy_d        = status_q[STAT_CARRY];
      end else begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        result_d    = res_c;
        status_d    = status_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      op_q        <= OP_NOP;
      mode_q      <= 1'b0;
      cy_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      mode_q      <= mode_d;
      cy_q        <= cy_d;
    end
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle ALU for the 20-bit CPU datapath. It supersedes the per-operation combinational circuits with one opcode-driven unit that has registered status flags, full/half-word modes and iterative multi-bit shifts/rotates. Operands arrive through a valid/ready handshake, and results leave through one. It sits between the register-file read stage and the write-back stage.

## Interface
- WIDTH, 20, full-word width; must be even and ≥ 4.
- HALF, WIDTH/2, half-word width; derived, not overridable.
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount field.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- opcode  in  5  operation (encodings in alu_pkg).
- mode  in  1  1 = full word (WIDTH), 0 = half word (HALF).
- a, b  in  WIDTH  operands; b[AMT_W-1:0] is the shift amount for shift and rotate ops.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result word.
- status  out  5  {trap, overflow, sign, carry, zero}; registered.

## Operation
- W_eff is WIDTH in full mode and HALF in half mode.
- Only the low W_eff bits of a and b are used. Result bits at W_eff and above are always 0.
- Single-cycle ops:
  - NOT, AND, OR, XOR: bitwise on W_eff bits.
  - INC, DEC: a ± 1.
  - ADD: a + b. ADC: a + b + carry.
  - SUB: a − b. SBC: a − b − carry, using two's complement.
- Carry is the carry-out of bit W_eff−1. For subtraction, carry is set on borrow (a < b + cin).
- Overflow is signed overflow at bit W_eff−1. It is updated only by ADD, ADC, SUB, SBC, INC and DEC.
- Sign is result[W_eff−1]; zero is (result == 0). Every op that writes a result updates both, except compares.
- Compares are unsigned on W_eff bits. Result is 0 and only zero/sign are written:
  - EQ: zero = (a==b).
  - GT: sign = (a<=b).
  - LT: sign = (a<b).
  - GE: zero = (a>=b), sign = ~zero.
  - LE: zero = sign = (a<=b).
- Shift and rotate ops are iterative, one bit per cycle:
  - Effective amount n = min(b[AMT_W-1:0], W_eff).
  - SHL shifts toward the MSB; SHR shifts toward the LSB; both fill with 0.
  - ROL and ROR rotate within W_eff bits.
  - For SHL/SHR, carry is the last bit shifted out; with n = 0, carry is unchanged.
  - Rotates do not change carry.
  - A shift by n = W_eff gives 0. A rotate by W_eff is the identity.
- System ops:
  - TRAP: sets trap; result 0.
  - RTT: clears trap; result 0.
  - LSTAT: result = zero-extended status.
  - XSTAT: result = a ^ zero-extended status if trap = 1, otherwise 0.
  - NOP and undefined opcodes: result 0, flags unchanged.
- FSM states:
  - IDLE: an accepted op with n > 0 goes to SHIFT; any other accepted op goes to DONE.
  - SHIFT: counter decrements each cycle; goes to DONE on the cycle it reaches 0.
  - DONE: out_valid = 1. If out_ready and in_valid, accept the new op (back-to-back). If out_ready alone, go to IDLE.
- Flags are written on the edge that enters DONE.
- Reset values: state IDLE, out_valid 0, result 0, status 0, in_ready 1.

## Timing
- Handshake:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - A request is accepted on an edge where in_valid & in_ready.
- Latency from accept to out_valid: 1 cycle for single-cycle ops, 1+n cycles for shifts and rotates.
- Throughput: one op per cycle while out_ready is held high and there are no shifts.
- While out_valid & !out_ready, result and status stay stable.
- in_ready is 0 throughout SHIFT; inputs are sampled only at accept.
- ADC/SBC read carry as it stands at accept, so the previous op's carry is already written.
- Asserting reset_n low at any point, including mid-SHIFT or while DONE is stalled:
  - the op is discarded and out_valid drops immediately;
  - all outputs take their reset values.

## Structure
- alu_pkg holds:
  - the opcode localparams (TRAP=0, NOP, NOT, AND, OR, XOR, SHL, SHR, ROL, ROR, INC, DEC, ADD, ADC, SUB, SBC, EQ, GT, LT, GE, LE, LSTAT, XSTAT, RTT);
  - the FSM state typedef;
  - the status bit index constants.
- One sub-module, seq_alu_comb: combinational single-cycle result and next-flags given opcode, mode, a, b and status.
- The shift datapath and FSM live in seq_alu.

## Test plan
- ADD, mode 1, a=0xFFFFF, b=0x00001 → 1 cycle later result 0x00000, zero=1, carry=1, overflow=0. Then ADC a=0, b=0 → result 0x00001, carry=0.
- Mode 0:
  - ADD a=0xABC05, b=0x00003 → result 0x00008.
  - INC a=0x003FF → result 0x00000, carry=1, zero=1.
- Shifts:
  - SHL, mode 1, a=0x00001, b=3 → result 0x00008, out_valid 4 cycles after accept, in_ready=0 during SHIFT.
  - SHL with b=25 → result 0, latency 21.
  - ROR, mode 0, a=0x00001, b=1 → result 0x00200.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR → result and status stable. Raise out_ready with in_valid high → new op accepted that edge and its result appears next cycle.
- Trap:
  - TRAP, then XSTAT a=0x00000 → result 0x00010.
  - RTT, then XSTAT → result 0.
  - LE a=5, b=5 → zero=1, sign=1.
- Reset: drop reset_n during SHL b=10 at cycle 4 → out_valid=0 and status=0 immediately. After release, the first ADD completes normally.
